// File: rtl/fdd_drive.sv
// fdd_drive -- behavioural model of one floppy disk drive on the FDD bus.
//
// The drive tracks head position, spins a motor through OFF/SPINUP/READY,
// generates the index pulse once per revolution and presents the active-low
// status lines when it is selected.
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   ce_1k             one-clk 1 kHz enable that times spin-up and rotation
//   USEL              unit select; the drive answers when USEL == DRIVE_ID
//   MOTORn            motor on (active low)
//   STEPn, SDIRn      step strobe (falling edge) and direction (0 = in)
//   SIDEn             head select (0 = side 1)
//   READYn, INDEXn, TRACK0n, WPROTn, READ_DATAn   active-low status lines
//   img_mounted       mount/eject strobe; img_size/img_readonly sampled on it
//   raw_pulse         flux pulse from the track serializer
//   cur_track, cur_side, spinning   head position, side and motor state
module fdd_drive #(
  parameter int DRIVE_ID  = 0,
  parameter int MAX_TRACK = 79,
  parameter int SPINUP_MS = 500,
  parameter int REV_MS    = 200,
  parameter int INDEX_MS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_1k,
  input  logic        USEL,
  input  logic        MOTORn,
  input  logic        STEPn,
  input  logic        SDIRn,
  input  logic        SIDEn,
  output logic        READYn,
  output logic        INDEXn,
  output logic        TRACK0n,
  output logic        WPROTn,
  output logic        READ_DATAn,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  input  logic        img_readonly,
  input  logic        raw_pulse,
  output logic [6:0]  cur_track,
  output logic        cur_side,
  output logic        spinning
);

  localparam int SW = $clog2(SPINUP_MS + 1);
  localparam int RW = $clog2(REV_MS + 1);

  localparam logic            SEL_VAL    = 1'(DRIVE_ID);
  localparam logic [SW-1:0]   SPIN_LAST  = SW'(SPINUP_MS - 1);
  localparam logic [RW-1:0]   REV_LAST   = RW'(REV_MS - 1);
  localparam logic [RW-1:0]   INDEX_END  = RW'(INDEX_MS);
  localparam logic [6:0]      TRACK_LAST = 7'(MAX_TRACK);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SPINUP = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   spin_q, spin_d;
  logic [RW-1:0]   rev_q, rev_d;
  logic [6:0]      track_q, track_d;
  logic            side_q;
  logic            sel_q;
  logic            present_q;
  logic            wprot_q;
  logic            stepn_q;
  logic            rd_q;

  logic            sel;
  logic            step_edge;
  logic [RW-1:0]   rev_next;

  assign sel = (USEL == SEL_VAL);
  // Falling edge of STEPn against the previous sample; a held-low strobe
  // therefore yields a single step.
  assign step_edge = sel & stepn_q & ~STEPn;
  assign rev_next  = (rev_q == REV_LAST) ? '0 : rev_q + 1'b1;

  always_comb begin
    state_d = state_q;
    spin_d  = spin_q;
    rev_d   = rev_q;
    if (MOTORn) begin
      // Motor off wins over a coincident ce_1k and clears both counters.
      state_d = ST_OFF;
      spin_d  = '0;
      rev_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_SPINUP;
          spin_d  = '0;
          rev_d   = '0;
        end
        ST_SPINUP: begin
          if (ce_1k) begin
            rev_d = rev_next;
            if (spin_q == SPIN_LAST) state_d = ST_READY;
            else                     spin_d  = spin_q + 1'b1;
          end
        end
        ST_READY: begin
          if (ce_1k) rev_d = rev_next;
        end
        default: begin
          state_d = ST_OFF;
          spin_d  = '0;
          rev_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    track_d = track_q;
    if (step_edge) begin
      if (!SDIRn) begin
        if (track_q != TRACK_LAST) track_d = track_q + 7'd1;
      end else begin
        if (track_q != 7'd0) track_d = track_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_OFF;
      spin_q    <= '0;
      rev_q     <= '0;
      track_q   <= 7'd0;
      side_q    <= 1'b0;
      sel_q     <= 1'b0;
      present_q <= 1'b0;
      wprot_q   <= 1'b0;
      stepn_q   <= 1'b1;
      rd_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      spin_q  <= spin_d;
      rev_q   <= rev_d;
      track_q <= track_d;
      side_q  <= ~SIDEn;
      sel_q   <= sel;
      stepn_q <= STEPn;
      if (img_mounted) begin
        present_q <= (img_size != 64'd0);
        wprot_q   <= img_readonly;
      end
      rd_q <= ~(raw_pulse & sel & (state_q == ST_READY) & present_q);
    end
  end

  // Status lines decode registered state, so a change of select or an eject
  // shows on the pins one clk after it is seen.
  assign READYn     = ~(sel_q & (state_q == ST_READY) & present_q);
  assign INDEXn     = ~(sel_q & present_q & (state_q != ST_OFF) & (rev_q < INDEX_END));
  assign TRACK0n    = ~(sel_q & (track_q == 7'd0));
  assign WPROTn     = ~(sel_q & present_q & wprot_q);
  assign READ_DATAn = rd_q;
  assign cur_track  = track_q;
  assign cur_side   = side_q;
  assign spinning   = (state_q != ST_OFF);

endmodule

// File: tb/tb_fdd_drive.sv
// Directed testbench for fdd_drive with default parameters (drive 0,
// 80 tracks, 500 ms spin-up, 200 ms revolution, 4 ms index).
module tb_fdd_drive;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1k;
  logic        USEL;
  logic        MOTORn;
  logic        STEPn;
  logic        SDIRn;
  logic        SIDEn;
  logic        READYn;
  logic        INDEXn;
  logic        TRACK0n;
  logic        WPROTn;
  logic        READ_DATAn;
  logic        img_mounted;
  logic [63:0] img_size;
  logic        img_readonly;
  logic        raw_pulse;
  logic [6:0]  cur_track;
  logic        cur_side;
  logic        spinning;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fdd_drive dut (
    .clk          (clk),
    .reset        (reset),
    .ce_1k        (ce_1k),
    .USEL         (USEL),
    .MOTORn       (MOTORn),
    .STEPn        (STEPn),
    .SDIRn        (SDIRn),
    .SIDEn        (SIDEn),
    .READYn       (READYn),
    .INDEXn       (INDEXn),
    .TRACK0n      (TRACK0n),
    .WPROTn       (WPROTn),
    .READ_DATAn   (READ_DATAn),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .raw_pulse    (raw_pulse),
    .cur_track    (cur_track),
    .cur_side     (cur_side),
    .spinning     (spinning)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    ce_1k = 1'b1;
    step_clk();
    ce_1k = 1'b0;
    step_clk();
  endtask

  task automatic mount(input logic [63:0] size, input logic ro);
    img_mounted  = 1'b1;
    img_size     = size;
    img_readonly = ro;
    step_clk();
    img_mounted  = 1'b0;
  endtask

  task automatic step_pulse();
    STEPn = 1'b0;
    step_clk();
    STEPn = 1'b1;
    step_clk();
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({READYn, INDEXn, TRACK0n, WPROTn, READ_DATAn} !== 5'b11111) begin
      errors++;
      $display("FAIL %s status: got %b want 11111", tag,
               {READYn, INDEXn, TRACK0n, WPROTn, READ_DATAn});
    end
    checks++;
    if (cur_track !== 7'd0 || cur_side !== 1'b0 || spinning !== 1'b0) begin
      errors++;
      $display("FAIL %s regs: track=%0d side=%b spin=%b want 0/0/0", tag,
               cur_track, cur_side, spinning);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce_1k = 1'b0; USEL = 1'b0; MOTORn = 1'b0; STEPn = 1'b1;
    SDIRn = 1'b0; SIDEn = 1'b0; img_mounted = 1'b0; img_size = 64'd0;
    img_readonly = 1'b0; raw_pulse = 1'b0;
    step_clk();
    step_clk();
    check_idle_outputs("reset");
    SIDEn  = 1'b1;
    MOTORn = 1'b1;
    reset  = 1'b0;
    step_clk();
  endtask

  task automatic test_spinup();
    int hi_bad;
    mount(64'd737280, 1'b0);
    step_clk();
    checks++;
    if (WPROTn !== 1'b1 || READYn !== 1'b1) begin
      errors++; $display("FAIL mount_rw: WPROTn=%b READYn=%b want 1 1", WPROTn, READYn);
    end
    MOTORn = 1'b0;
    step_clk();
    checks++;
    if (spinning !== 1'b1) begin
      errors++; $display("FAIL spin_start: spinning=%b want 1", spinning);
    end
    hi_bad = 0;
    for (int i = 1; i <= 499; i++) begin
      tick();
      if (READYn !== 1'b1) hi_bad++;
    end
    checks++;
    if (hi_bad !== 0) begin
      errors++; $display("FAIL spinup_wait: READYn low on %0d of 499 ticks want 0", hi_bad);
    end
    tick();
    checks++;
    if (READYn !== 1'b0) begin
      errors++; $display("FAIL spinup_done: READYn=%b want 0", READYn);
    end
  endtask

  task automatic test_index();
    int lows;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (INDEXn === 1'b0) lows++;
    end
    checks++;
    if (lows !== 4) begin
      errors++; $display("FAIL index_width: INDEXn low %0d ticks want 4", lows);
    end
  endtask

  task automatic test_read_select();
    raw_pulse = 1'b1;
    #1;
    checks++;
    if (READ_DATAn !== 1'b1) begin
      errors++; $display("FAIL rd_before: READ_DATAn=%b want 1", READ_DATAn);
    end
    step_clk();
    raw_pulse = 1'b0;
    checks++;
    if (READ_DATAn !== 1'b0) begin
      errors++; $display("FAIL rd_pulse: READ_DATAn=%b want 0", READ_DATAn);
    end
    step_clk();
    checks++;
    if (READ_DATAn !== 1'b1) begin
      errors++; $display("FAIL rd_after: READ_DATAn=%b want 1", READ_DATAn);
    end
    SIDEn = 1'b0;
    step_clk();
    checks++;
    if (cur_side !== 1'b1) begin
      errors++; $display("FAIL side: cur_side=%b want 1", cur_side);
    end
    SIDEn = 1'b1;
    USEL = 1'b1;
    step_clk();
    checks++;
    if (READYn !== 1'b1 || TRACK0n !== 1'b1 || spinning !== 1'b1) begin
      errors++; $display("FAIL desel: READYn=%b TRACK0n=%b spin=%b want 1 1 1",
                         READYn, TRACK0n, spinning);
    end
    raw_pulse = 1'b1;
    step_clk();
    raw_pulse = 1'b0;
    checks++;
    if (READ_DATAn !== 1'b1) begin
      errors++; $display("FAIL rd_desel: READ_DATAn=%b want 1", READ_DATAn);
    end
    USEL = 1'b0;
    step_clk();
    checks++;
    if (READYn !== 1'b0 || cur_side !== 1'b0) begin
      errors++; $display("FAIL resel: READYn=%b side=%b want 0 0", READYn, cur_side);
    end
  endtask

  task automatic test_wprot();
    mount(64'd737280, 1'b1);
    checks++;
    if (WPROTn !== 1'b0) begin
      errors++; $display("FAIL wprot: WPROTn=%b want 0", WPROTn);
    end
  endtask

  task automatic test_step();
    SDIRn = 1'b0;
    STEPn = 1'b0;
    step_clk();
    checks++;
    if (cur_track !== 7'd1 || TRACK0n !== 1'b1) begin
      errors++; $display("FAIL step_first: track=%0d TRACK0n=%b want 1 1", cur_track, TRACK0n);
    end
    STEPn = 1'b1;
    step_clk();
    for (int i = 0; i < 84; i++) step_pulse();
    checks++;
    if (cur_track !== 7'd79 || TRACK0n !== 1'b1) begin
      errors++; $display("FAIL step_in_sat: track=%0d TRACK0n=%b want 79 1", cur_track, TRACK0n);
    end
    SDIRn = 1'b1;
    for (int i = 0; i < 90; i++) step_pulse();
    checks++;
    if (cur_track !== 7'd0 || TRACK0n !== 1'b0) begin
      errors++; $display("FAIL step_out_sat: track=%0d TRACK0n=%b want 0 0", cur_track, TRACK0n);
    end
  endtask

  task automatic test_step_hold();
    SDIRn = 1'b0;
    STEPn = 1'b0;
    for (int i = 0; i < 1000; i++) step_clk();
    STEPn = 1'b1;
    step_clk();
    checks++;
    if (cur_track !== 7'd1) begin
      errors++; $display("FAIL step_hold: track=%0d want 1", cur_track);
    end
  endtask

  task automatic test_eject();
    mount(64'd0, 1'b0);
    checks++;
    if (READYn !== 1'b1 || INDEXn !== 1'b1 || spinning !== 1'b1 || WPROTn !== 1'b1) begin
      errors++; $display("FAIL eject: READYn=%b INDEXn=%b spin=%b WPROTn=%b want 1 1 1 1",
                         READYn, INDEXn, spinning, WPROTn);
    end
  endtask

  task automatic test_step_with_mount();
    STEPn = 1'b0;
    mount(64'd737280, 1'b0);
    checks++;
    if (cur_track !== 7'd2 || READYn !== 1'b0 || WPROTn !== 1'b1) begin
      errors++; $display("FAIL step_mount: track=%0d READYn=%b WPROTn=%b want 2 0 1",
                         cur_track, READYn, WPROTn);
    end
    STEPn = 1'b1;
    step_clk();
  endtask

  task automatic test_motor_off_ce();
    MOTORn = 1'b1;
    ce_1k  = 1'b1;
    step_clk();
    ce_1k  = 1'b0;
    checks++;
    if (spinning !== 1'b0 || READYn !== 1'b1 || INDEXn !== 1'b1) begin
      errors++; $display("FAIL motor_off: spin=%b READYn=%b INDEXn=%b want 0 1 1",
                         spinning, READYn, INDEXn);
    end
    MOTORn = 1'b0;
    step_clk();
    checks++;
    if (spinning !== 1'b1 || INDEXn !== 1'b0 || READYn !== 1'b1) begin
      errors++; $display("FAIL motor_restart: spin=%b INDEXn=%b READYn=%b want 1 0 1",
                         spinning, INDEXn, READYn);
    end
  endtask

  task automatic test_reset_spinup();
    mount(64'd737280, 1'b1);
    for (int i = 0; i < 300; i++) tick();
    checks++;
    if (READYn !== 1'b1 || WPROTn !== 1'b0 || cur_track !== 7'd2) begin
      errors++; $display("FAIL mid_spinup: READYn=%b WPROTn=%b track=%0d want 1 0 2",
                         READYn, WPROTn, cur_track);
    end
    reset = 1'b1;
    ce_1k = 1'b1;
    STEPn = 1'b0;
    step_clk();
    check_idle_outputs("reset_spinup");
    reset = 1'b0;
    ce_1k = 1'b0;
    STEPn = 1'b1;
    step_clk();
  endtask

  initial begin
    test_reset();
    test_spinup();
    test_index();
    test_read_select();
    test_wprot();
    test_step();
    test_step_hold();
    test_eject();
    test_step_with_mount();
    test_motor_off_ce();
    test_reset_spinup();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fdd_drive.md
FDD_DRIVE -- requirements
Module: fdd_drive

Interface
REQ-001 Parameter DRIVE_ID, default 0: unit number; drive is selected when USEL equals DRIVE_ID.
REQ-002 Parameter MAX_TRACK, default 79: highest head position.
REQ-003 Parameter SPINUP_MS, default 500: ce_1k ticks from motor-on to ready.
REQ-004 Parameter REV_MS, default 200: ce_1k ticks per revolution (300 rpm).
REQ-005 Parameter INDEX_MS, default 4: width of the index pulse in ce_1k ticks.
REQ-006 Port clk, input, 1: single system clock.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port ce_1k, input, 1: one-clk 1 kHz clock enable from the clock bus.
REQ-009 Port USEL, input, 1: unit select.
REQ-010 Port MOTORn, input, 1: motor on, active low.
REQ-011 Port STEPn, input, 1: step strobe, active low.
REQ-012 Port SDIRn, input, 1: 0 = step in (track+1), 1 = step out (track-1).
REQ-013 Port SIDEn, input, 1: 0 = side 1, 1 = side 0.
REQ-014 Ports READYn, INDEXn, TRACK0n, WPROTn, READ_DATAn, each output, 1: FDD_mp status lines, active low.
REQ-015 Port img_mounted, input, 1: one-clk mount/eject strobe.
REQ-016 Port img_size, input, 64: image size in bytes, sampled on img_mounted.
REQ-017 Port img_readonly, input, 1: write-protect flag, sampled on img_mounted.
REQ-018 Port raw_pulse, input, 1: flux pulse from the track serializer.
REQ-019 Port cur_track, output, 7: head position.
REQ-020 Port cur_side, output, 1: selected side.
REQ-021 Port spinning, output, 1: motor state is not OFF.

Function
REQ-022 sel = (USEL == DRIVE_ID).
REQ-023 On img_mounted: disk_present <= (img_size != 0); wprot <= img_readonly.
- An eject (img_mounted with img_size == 0) forces READYn high in the next cycle.
REQ-024 Motor FSM states: OFF, SPINUP, READY.
- OFF->SPINUP when MOTORn=0; the spin counter clears.
- SPINUP counts ce_1k ticks; SPINUP->READY when the count reaches SPINUP_MS-1 on a ce_1k.
- Any state ->OFF when MOTORn=1, taking effect the next clk.
REQ-025 READYn = ~(sel & state==READY & disk_present).
REQ-026 Revolution counter, 0..REV_MS-1:
- Advances on ce_1k while state != OFF and wraps to 0.
- Held at 0 in OFF.
REQ-027 INDEXn = ~(sel & disk_present & state!=OFF & rev_cnt < INDEX_MS).
REQ-028 Step detection uses the registered STEPn falling edge while sel=1:
- One step per edge, independent of the motor.
- cur_track updates one clk after the edge.
REQ-029 Step in saturates at MAX_TRACK; step out saturates at 0; no wrap-around.
REQ-030 TRACK0n = ~(sel & cur_track==0); the head position does not depend on disk_present.
REQ-031 WPROTn = ~(sel & disk_present & wprot).
REQ-032 READ_DATAn = ~(raw_pulse & sel & state==READY & disk_present), registered, one-clk latency.
REQ-033 cur_side = ~SIDEn, registered.
REQ-034 If select is lost, all status outputs return high on the next clk.
- The FSM, counters and head position continue unaffected.
REQ-035 A STEPn edge coinciding with img_mounted is processed; a mount does not move the head.
REQ-036 A ce_1k coinciding with a MOTORn=1 transition: OFF wins and the counters clear.

Reset
REQ-037 On reset, all of the following take effect in the same clk, overriding all other events:
- state=OFF, rev_cnt=0, spin counter=0, cur_track=0, cur_side=0.
- disk_present=0, wprot=0, stored STEPn=1, spinning=0.
- READYn=INDEXn=WPROTn=READ_DATAn=1, TRACK0n=1.
REQ-038 Reset asserted mid-spin-up or mid-step abandons the operation; there are no partial updates.

Verification
REQ-039 Mount 720 KB (img_size=737280), sel, MOTORn=0:
- READYn=1 for 499 ce_1k ticks, then 0 after the 500th tick.
- INDEXn low for 4 of every 200 ticks.
REQ-040 sel, SDIRn=0, 85 STEPn pulses: cur_track reaches 79 and holds; TRACK0n=1. Then SDIRn=1, 90 pulses: cur_track=0, TRACK0n=0.
REQ-041 READY with a 1-clk raw_pulse: READ_DATAn=0 exactly one clk later for one clk. With USEL != DRIVE_ID: READ_DATAn stays 1.
REQ-042 Eject while READY (img_mounted, img_size=0): READYn=1 and INDEXn=1 the next clk; spinning stays 1.
REQ-043 Mount with img_readonly=1: WPROTn=0 while selected. Reset during SPINUP at tick 300: all outputs as in REQ-037, cur_track=0.
REQ-044 STEPn held low for 1000 clks produces exactly one step.
